interconn_recv_buffer: RTL and testbench

Per-MVU receive endpoint of the priority interconnect. It accepts the interconnect's `recv_en`/`recv_from`/`recv_addr`/`recv_word` beats, which arrive with no backpressure, and queues them in a small FIFO. It drains the FIFO into the local MVU data-memory write port, which the local MVU can stall. It flags malformed sources and overflows with sticky error bits. One instance sits between each interconnect output lane and its MVU's memory arbiter.

---
 rtl/interconn_recv_buffer.sv | 157 +++++++++++++++
 tb/tb_interconn_recv_buffer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/interconn_recv_buffer.sv
// ----------------------------------------------------------------------------
// interconn_recv_buffer
//
// This is the receive endpoint of the priority interconnect for one MVU.
// Each interconnect output lane feeds one instance, and the instance feeds
// that MVU's memory arbiter.
//
// Beats from the interconnect cannot be back-pressured. The block queues
// them in a small FIFO of DEPTH entries. It then drains the FIFO into the
// MVU data-memory write port. The local MVU can stall that port with
// mem_stall.
//
// Error handling:
//   - A beat whose source field is not one-hot is dropped and raises src_err.
//   - A beat that arrives while the FIFO is full and nothing pops is dropped
//     and raises ovf.
//   - Both error bits are sticky. err_clr clears them; a new error on the
//     same edge wins over the clear.
//
// Optional build macro: INTERCONN_RECV_BYPASS_EN
//   When defined, a good beat that arrives while the FIFO is truly empty
//   and the port is not stalled goes straight to the output register.
//   This gives 1-cycle latency instead of 2.
//
// Ports:
//   clk        clock, rising edge
//   clr_n      asynchronous active-low reset
//   recv_en    beat valid from interconnect
//   recv_from  one-hot source MVU of the beat [N]
//   recv_addr  destination memory address [BADDR]
//   recv_word  data word [W]
//   mem_stall  local MVU owns the memory port; blocks the next write
//   mem_we     write strobe, one cycle per word
//   mem_addr   write address [BADDR]
//   mem_word   write data [W]
//   mem_from   one-hot source of the word being written [N]
//   count      FIFO occupancy [$clog2(DEPTH)+1]
//   ovf        sticky: beat dropped, FIFO full
//   src_err    sticky: beat dropped, recv_from not one-hot
//   err_clr    synchronous clear of ovf / src_err
// ----------------------------------------------------------------------------
module interconn_recv_buffer #(
  parameter int N     = 8,
  parameter int W     = 64,
  parameter int BADDR = 15,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     clr_n,
  input  logic                     recv_en,
  input  logic [N-1:0]             recv_from,
  input  logic [BADDR-1:0]         recv_addr,
  input  logic [W-1:0]             recv_word,
  input  logic                     mem_stall,
  output logic                     mem_we,
  output logic [BADDR-1:0]         mem_addr,
  output logic [W-1:0]             mem_word,
  output logic [N-1:0]             mem_from,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     ovf,
  output logic                     src_err,
  input  logic                     err_clr
);

  localparam int PW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit, so full and empty can be told apart.
  logic [PW:0]      r_wptr, r_rptr;
  logic [N-1:0]     r_from_q [DEPTH];
  logic [BADDR-1:0] r_addr_q [DEPTH];
  logic [W-1:0]     r_word_q [DEPTH];

  logic             r_we;
  logic [BADDR-1:0] r_addr;
  logic [W-1:0]     r_word;
  logic [N-1:0]     r_from;
  logic             r_ovf, r_src_err;

  logic             w_empty, w_full, w_onehot, w_good;
  logic             w_pop, w_byp, w_push, w_drop_ovf, w_drop_src;
  logic [PW-1:0]    w_widx, w_ridx;

  assign w_widx   = r_wptr[PW-1:0];
  assign w_ridx   = r_rptr[PW-1:0];
  assign w_empty  = (r_wptr == r_rptr);
  assign w_full   = (r_wptr[PW] != r_rptr[PW]) && (w_widx == w_ridx);
  assign w_onehot = $onehot(recv_from);
  assign w_good   = recv_en && w_onehot;

  assign w_pop    = !w_empty && !mem_stall;

`ifdef INTERCONN_RECV_BYPASS_EN
  // Only a truly empty FIFO qualifies. A FIFO whose last entry is popping
  // on this edge does not, because that entry must be written first.
  assign w_byp    = w_good && w_empty && !mem_stall;
`else
  assign w_byp    = 1'b0;
`endif

  // When full, a push is still accepted if the head pops on the same edge.
  // Write and read then hit the same slot. The read takes the old contents,
  // because both sides are non-blocking.
  assign w_push     = w_good && !w_byp && (!w_full || w_pop);
  assign w_drop_ovf = w_good && w_full && !w_pop;
  assign w_drop_src = recv_en && !w_onehot;

  // FIFO storage has no reset. The pointers alone decide which entries are
  // valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_from_q[w_widx] <= recv_from;
      r_addr_q[w_widx] <= recv_addr;
      r_word_q[w_widx] <= recv_word;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_word    <= '0;
      r_from    <= '0;
      r_ovf     <= 1'b0;
      r_src_err <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;

      r_we <= w_pop || w_byp;
      // Output data holds its last value while no write is issued.
      if (w_pop) begin
        r_addr <= r_addr_q[w_ridx];
        r_word <= r_word_q[w_ridx];
        r_from <= r_from_q[w_ridx];
      end else if (w_byp) begin
        r_addr <= recv_addr;
        r_word <= recv_word;
        r_from <= recv_from;
      end

      // Sticky error bits; a new error on the clearing edge wins.
      r_ovf     <= (r_ovf     && !err_clr) || w_drop_ovf;
      r_src_err <= (r_src_err && !err_clr) || w_drop_src;
    end
  end

  assign mem_we   = r_we;
  assign mem_addr = r_addr;
  assign mem_word = r_word;
  assign mem_from = r_from;
  assign count    = r_wptr - r_rptr;
  assign ovf      = r_ovf;
  assign src_err  = r_src_err;

endmodule

// File: tb/tb_interconn_recv_buffer.sv
module tb_interconn_recv_buffer;

  localparam int N = 8, W = 64, BADDR = 15, DEPTH = 4;

  logic             clk = 1'b0;
  logic             clr_n;
  logic             recv_en;
  logic [N-1:0]     recv_from;
  logic [BADDR-1:0] recv_addr;
  logic [W-1:0]     recv_word;
  logic             mem_stall;
  logic             mem_we;
  logic [BADDR-1:0] mem_addr;
  logic [W-1:0]     mem_word;
  logic [N-1:0]     mem_from;
  logic [2:0]       count;
  logic             ovf, src_err, err_clr;

  int checks = 0;
  int errors = 0;

  interconn_recv_buffer #(.N(N), .W(W), .BADDR(BADDR), .DEPTH(DEPTH)) dut (
    .clk(clk), .clr_n(clr_n), .recv_en(recv_en), .recv_from(recv_from),
    .recv_addr(recv_addr), .recv_word(recv_word), .mem_stall(mem_stall),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_word(mem_word),
    .mem_from(mem_from), .count(count), .ovf(ovf), .src_err(src_err),
    .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [N-1:0] f, input logic [BADDR-1:0] a, input logic [W-1:0] w);
    recv_en = 1'b1; recv_from = f; recv_addr = a; recv_word = w;
  endtask

  initial begin
    clr_n = 1'b0; recv_en = 1'b0; recv_from = '0; recv_addr = '0;
    recv_word = '0; mem_stall = 1'b0; err_clr = 1'b0;
    tick(); tick();
    chk("rst_we", {63'd0, mem_we}, 64'd0);
    chk("rst_count", {61'd0, count}, 64'd0);
    chk("rst_ovf", {63'd0, ovf}, 64'd0);
    chk("rst_src", {63'd0, src_err}, 64'd0);
    chk("rst_addr", {49'd0, mem_addr}, 64'd0);
    chk("rst_word", mem_word, 64'd0);
    chk("rst_from", {56'd0, mem_from}, 64'd0);
    clr_n = 1'b1;
    tick();

    // Single beat
    beat(8'h04, 15'h0011, 64'hdeadbeefdeadbeef);
    tick();
    recv_en = 1'b0;
`ifdef INTERCONN_RECV_BYPASS_EN
    chk("s_byp_we", {63'd0, mem_we}, 64'd1);
    chk("s_byp_cnt", {61'd0, count}, 64'd0);
`else
    chk("s_we0", {63'd0, mem_we}, 64'd0);
    chk("s_cnt1", {61'd0, count}, 64'd1);
    tick();
    chk("s_we1", {63'd0, mem_we}, 64'd1);
`endif
    chk("s_addr", {49'd0, mem_addr}, 64'h11);
    chk("s_word", mem_word, 64'hdeadbeefdeadbeef);
    chk("s_from", {56'd0, mem_from}, 64'h04);
    chk("s_cnt0", {61'd0, count}, 64'd0);
    tick();
    chk("s_we_off", {63'd0, mem_we}, 64'd0);
    chk("s_hold", {49'd0, mem_addr}, 64'h11);

    // Stall / backlog: 6 stalled cycles with 4 beats
    mem_stall = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      if (i <= 4) beat(8'h01, 15'(i), 64'(i) * 64'h100);
      else recv_en = 1'b0;
      tick();
      chk("b_nowe", {63'd0, mem_we}, 64'd0);
    end
    recv_en = 1'b0;
    chk("b_cnt4", {61'd0, count}, 64'd4);
    mem_stall = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("b_we", {63'd0, mem_we}, 64'd1);
      chk("b_addr", {49'd0, mem_addr}, 64'(i));
      chk("b_word", mem_word, 64'(i) * 64'h100);
      chk("b_cnt", {61'd0, count}, 64'(4 - i));
    end
    tick();
    chk("b_done", {63'd0, mem_we}, 64'd0);
    chk("b_ovf", {63'd0, ovf}, 64'd0);

    // Overflow: the 5th beat is dropped
    mem_stall = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      beat(8'h02, 15'(i), 64'(i));
      tick();
    end
    recv_en = 1'b0;
    chk("o_ovf", {63'd0, ovf}, 64'd1);
    chk("o_cnt", {61'd0, count}, 64'd4);
    mem_stall = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("o_we", {63'd0, mem_we}, 64'd1);
      chk("o_addr", {49'd0, mem_addr}, 64'(i));
    end
    tick();
    chk("o_no5", {63'd0, mem_we}, 64'd0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("o_clr", {63'd0, ovf}, 64'd0);

    // Full FIFO: push and pop on the same edge
    mem_stall = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      beat(8'h80, 15'(i), 64'(i) + 64'hA0);
      tick();
    end
    chk("f_cnt4", {61'd0, count}, 64'd4);
    mem_stall = 1'b0;
    beat(8'h80, 15'd5, 64'hA5);
    tick();
    recv_en = 1'b0;
    chk("f_cnt_keep", {61'd0, count}, 64'd4);
    chk("f_ovf", {63'd0, ovf}, 64'd0);
    chk("f_we1", {63'd0, mem_we}, 64'd1);
    chk("f_a1", {49'd0, mem_addr}, 64'd1);
    for (int i = 2; i <= 5; i++) begin
      tick();
      chk("f_we", {63'd0, mem_we}, 64'd1);
      chk("f_addr", {49'd0, mem_addr}, 64'(i));
      chk("f_word", mem_word, 64'(i) + 64'hA0);
      chk("f_from", {56'd0, mem_from}, 64'h80);
    end
    tick();
    chk("f_done", {63'd0, mem_we}, 64'd0);
    chk("f_cnt0", {61'd0, count}, 64'd0);

    // Bad source fields are dropped
    beat(8'h00, 15'h10, 64'h1);
    tick();
    chk("e_src0", {63'd0, src_err}, 64'd1);
    beat(8'h03, 15'h11, 64'h2);
    tick();
    recv_en = 1'b0;
    chk("e_src3", {63'd0, src_err}, 64'd1);
    chk("e_cnt", {61'd0, count}, 64'd0);
    chk("e_we_a", {63'd0, mem_we}, 64'd0);
    tick();
    chk("e_we_b", {63'd0, mem_we}, 64'd0);
    err_clr = 1'b1;
    beat(8'h00, 15'h12, 64'h3);
    tick();
    recv_en = 1'b0;
    chk("e_setwins", {63'd0, src_err}, 64'd1);
    tick();
    err_clr = 1'b0;
    chk("e_clr", {63'd0, src_err}, 64'd0);

    // Reset while the FIFO is draining
    mem_stall = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      beat(8'h10, 15'(i + 20), 64'(i));
      tick();
    end
    recv_en = 1'b0;
    chk("r_cnt3", {61'd0, count}, 64'd3);
    mem_stall = 1'b0;
    tick();
    chk("r_we_pre", {63'd0, mem_we}, 64'd1);
    #2 clr_n = 1'b0;
    #1;
    chk("r_cnt0", {61'd0, count}, 64'd0);
    chk("r_we0", {63'd0, mem_we}, 64'd0);
    chk("r_addr0", {49'd0, mem_addr}, 64'd0);
    tick();
    clr_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("r_stale", {63'd0, mem_we}, 64'd0);
    end
    chk("r_cnt_end", {61'd0, count}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
